// File: rtl/vga_tile_ctrl.sv
// VGA timing generator with a TILES_X x TILES_Y coloured tile grid; one tile can be
// highlighted at full intensity for a whole number of frames, all others are dimmed.
module vga_tile_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TILES_X  = 2,
  parameter int TILES_Y  = 2,
  parameter int COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hl_valid,
  output logic               hl_ready,
  input  logic [3:0]         hl_tile,
  input  logic [7:0]         hl_frames,
  output logic               busy,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TW      = H_ACTIVE / TILES_X;
  localparam int TH      = V_ACTIVE / TILES_Y;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int TWW     = $clog2(TW + 1);
  localparam int THW     = $clog2(TH + 1);
  localparam int TXW     = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int TYW     = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

  localparam logic [DW-1:0]      DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]      H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]      H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]      HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]      HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]      V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]      V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]      VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]      VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TWW-1:0]     TW_LAST  = TWW'(TW - 1);
  localparam logic [THW-1:0]     TH_LAST  = THW'(TH - 1);
  localparam logic [TXW-1:0]     TX_LAST  = TXW'(TILES_X - 1);
  localparam logic [TYW-1:0]     TY_LAST  = TYW'(TILES_Y - 1);
  localparam logic [COLOR_W-1:0] C_ONES   = '1;
  localparam logic [COLOR_W-1:0] C_HALF   = C_ONES ^ (C_ONES >> 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t               state;
  logic [3:0]           tile_q;
  logic [7:0]           frames_q;
  logic [7:0]           remaining;

  logic [DW-1:0]        div;
  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic [TWW-1:0]       hx;
  logic [THW-1:0]       vy;
  logic [TXW-1:0]       tx;
  logic [TYW-1:0]       ty;
  logic                 tick, h_wrap, v_wrap, frame_evt;

  assign tick      = (div == DIV_LAST);
  assign h_wrap    = tick && (h == H_LAST);
  assign v_wrap    = h_wrap && (v == V_LAST);
  assign frame_evt = tick && (h == '0) && (v == '0);

  // Tile column/row are running counters; they saturate at the last tile so
  // blanking regions never produce an out-of-range index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
      hx  <= '0;
      vy  <= '0;
      tx  <= '0;
      ty  <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h_wrap) begin
          h  <= '0;
          hx <= '0;
          tx <= '0;
        end else begin
          h <= h + 1'b1;
          if (hx == TW_LAST) begin
            hx <= '0;
            if (tx != TX_LAST) tx <= tx + 1'b1;
          end else begin
            hx <= hx + 1'b1;
          end
        end
        if (h_wrap) begin
          if (v_wrap) begin
            v  <= '0;
            vy <= '0;
            ty <= '0;
          end else begin
            v <= v + 1'b1;
            if (vy == TH_LAST) begin
              vy <= '0;
              if (ty != TY_LAST) ty <= ty + 1'b1;
            end else begin
              vy <= vy + 1'b1;
            end
          end
        end
      end
    end
  end

  // Returns {grey, r, g, b} for palette slot k.
  function automatic logic [3:0] palette(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0100;
      3'd1:    return 4'b0010;
      3'd2:    return 4'b0001;
      3'd3:    return 4'b0011;
      3'd4:    return 4'b0101;
      3'd5:    return 4'b0110;
      3'd6:    return 4'b0111;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [COLOR_W-1:0] shade(input logic on, input logic grey,
                                               input logic full);
    logic [COLOR_W-1:0] c;
    c = grey ? C_HALF : (on ? C_ONES : '0);
    return full ? c : (c >> 1);
  endfunction

  logic [7:0]         tile_k;
  logic [3:0]         pal;
  logic               active, lit;
  logic [COLOR_W-1:0] r_nx, g_nx, b_nx;

  always_comb begin
    tile_k = 8'(ty) * 8'(TILES_X) + 8'(tx);
    pal    = palette(tile_k[2:0]);
    active = (h < H_ACT) && (v < V_ACT);
    lit    = (state == SHOW) && (tile_k == {4'b0, tile_q});
    r_nx   = '0;
    g_nx   = '0;
    b_nx   = '0;
    if (active) begin
      r_nx = shade(pal[2], pal[3], lit);
      g_nx = shade(pal[1], pal[3], lit);
      b_nx = shade(pal[0], pal[3], lit);
    end
  end

  // Single output stage: sync, colour and frame_start all come from the same
  // pre-increment position, so they stay aligned on the pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      frame_start <= frame_evt;
      if (tick) begin
        hsync <= !((h >= HS_BEG) && (h < HS_END));
        vsync <= !((v >= VS_BEG) && (v < VS_END));
        red   <= r_nx;
        green <= g_nx;
        blue  <= b_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tile_q    <= '0;
      frames_q  <= '0;
      remaining <= '0;
      hl_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hl_valid) begin
          tile_q   <= hl_tile;
          frames_q <= (hl_frames == 8'd0) ? 8'd1 : hl_frames;
          state    <= ARMED;
          hl_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ARMED: if (frame_evt) begin
          remaining <= frames_q;
          state     <= SHOW;
        end
        SHOW: if (frame_evt) begin
          if (remaining == 8'd1) begin
            state    <= IDLE;
            hl_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            remaining <= remaining - 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hl_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
